mem_arbiter: RTL and testbench

Arbitrates the single unified memory port between the instruction fetch path and the data (load/store) path of the pipelined core. It produces the ihit/dhit handshakes that feed the hazard unit and the pipeline stalls. A registered Moore FSM serves one transaction at a time. Data has priority over instruction, and a bounded starvation guard protects instruction fetch.

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the unified memory port
// and the arbiter that owns it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iren;
  logic [ADDR_W-1:0] iaddr;
  logic              ihit;
  logic [DATA_W-1:0] iload;

  logic              dren;
  logic              dwen;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dhit;
  logic [DATA_W-1:0] dload;

  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_ready;

  logic              busy;

  // Arbiter side.
  modport slave (
    input  iren, iaddr, dren, dwen, daddr, dstore, ram_load, ram_ready,
    output ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_store, busy
  );

  // Requester/memory side.
  modport master (
    output iren, iaddr, dren, dwen, daddr, dstore, ram_load, ram_ready,
    input  ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_store, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Unified memory port arbiter: one transaction at a time, data before
// instruction, with a bounded starvation guard for instruction fetch.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IACC = 2'd1;
  localparam logic [1:0] DACC = 2'd2;

  localparam logic [3:0]        LIMIT  = 4'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] ZERO_A = '0;
  localparam logic [DATA_W-1:0] ZERO_D = '0;

  logic [1:0] state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       d_is_write, d_is_write_nxt;
  logic       d_req;
  logic       starved;

  assign d_req   = bus.dren | bus.dwen;
  assign starved = bus.iren && (starve_cnt == LIMIT);

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    starve_nxt     = starve_cnt;
    d_is_write_nxt = d_is_write;
    case (state)
      IDLE: begin
        if (d_req && !starved) begin
          state_nxt      = DACC;
          d_is_write_nxt = bus.dwen;
          if (!bus.iren)
            starve_nxt = 4'd0;
          else if (starve_cnt != LIMIT)
            starve_nxt = starve_cnt + 4'd1;
        end else if (bus.iren) begin
          state_nxt  = IACC;
          starve_nxt = 4'd0;
        end
      end
      // A dropped iren is a flushed fetch; it wins over a coincident ready.
      IACC: if (!bus.iren || bus.ram_ready) state_nxt = IDLE;
      DACC: if (bus.ram_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      d_is_write <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      d_is_write <= d_is_write_nxt;
    end
  end

  // Strobes are Moore outputs of the state; hits follow ram_ready in-cycle.
  always_comb begin
    bus.ihit      = 1'b0;
    bus.iload     = ZERO_D;
    bus.dhit      = 1'b0;
    bus.dload     = ZERO_D;
    bus.ram_ren   = 1'b0;
    bus.ram_wen   = 1'b0;
    bus.ram_addr  = ZERO_A;
    bus.ram_store = ZERO_D;
    bus.busy      = 1'b0;
    case (state)
      IACC: begin
        bus.busy     = 1'b1;
        bus.ram_ren  = 1'b1;
        bus.ram_addr = bus.iaddr;
        if (bus.iren && bus.ram_ready) begin
          bus.ihit  = 1'b1;
          bus.iload = bus.ram_load;
        end
      end
      DACC: begin
        bus.busy     = 1'b1;
        bus.ram_ren  = !d_is_write;
        bus.ram_wen  = d_is_write;
        bus.ram_addr = bus.daddr;
        if (d_is_write)
          bus.ram_store = bus.dstore;
        if (bus.ram_ready) begin
          bus.dhit = 1'b1;
          if (!d_is_write)
            bus.dload = bus.ram_load;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level owner model.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LIMIT  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who currently owns the memory port (0 none, 1 fetch,
  // 2 data), how many data grants in a row fetch has waited, and access kind.
  int m_owner  = 0;
  int m_starve = 0;
  bit m_dwrite = 1'b0;

  // Agent controls.
  bit          hold_i = 1'b0, hold_d = 1'b0, rand_mode = 1'b0, rand_load = 1'b1;
  int          mem_lat = 1;
  int          acc_cyc = 0;
  logic [31:0] fixed_load = 32'h0;

  // Observations for directed checks.
  int          ihits, dhits, ren_cnt, wen_cnt;
  logic [31:0] last_iload, last_dload;
  string       seq;

  logic        e_ren, e_wen, e_ihit, e_dhit, e_busy;
  logic [31:0] e_addr, e_store, e_iload, e_dload;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    ihits = 0; dhits = 0; ren_cnt = 0; wen_cnt = 0;
    last_iload = 32'h0; last_dload = 32'h0; seq = "";
  endtask

  task automatic cycle();
    bit d_req;
    @(negedge clk);
    e_ren = 0; e_wen = 0; e_ihit = 0; e_dhit = 0;
    e_addr = 0; e_store = 0; e_iload = 0; e_dload = 0;
    if (m_owner == 1) begin
      e_ren  = 1;
      e_addr = bus.iaddr;
      e_ihit = bus.iren && bus.ram_ready;
      if (e_ihit) e_iload = bus.ram_load;
    end else if (m_owner == 2) begin
      e_ren  = !m_dwrite;
      e_wen  = m_dwrite;
      e_addr = bus.daddr;
      if (m_dwrite) e_store = bus.dstore;
      e_dhit = bus.ram_ready;
      if (e_dhit && !m_dwrite) e_dload = bus.ram_load;
    end
    e_busy = (m_owner != 0);
    if (!rst) begin
      chk("ihit",      32'(bus.ihit),    32'(e_ihit));
      chk("iload",     bus.iload,        e_iload);
      chk("dhit",      32'(bus.dhit),    32'(e_dhit));
      chk("dload",     bus.dload,        e_dload);
      chk("ram_ren",   32'(bus.ram_ren), 32'(e_ren));
      chk("ram_wen",   32'(bus.ram_wen), 32'(e_wen));
      chk("ram_addr",  bus.ram_addr,     e_addr);
      chk("ram_store", bus.ram_store,    e_store);
      chk("busy",      32'(bus.busy),    32'(e_busy));
    end
    if (bus.ihit) begin ihits++; last_iload = bus.iload; seq = {seq, "I"}; end
    if (bus.dhit) begin dhits++; last_dload = bus.dload; seq = {seq, "D"}; end
    if (bus.ram_ren) ren_cnt++;
    if (bus.ram_wen) wen_cnt++;

    @(posedge clk);
    d_req = bus.dren || bus.dwen;
    if (rst) begin
      m_owner = 0; m_starve = 0; m_dwrite = 0;
    end else if (m_owner == 0) begin
      if (d_req && !(bus.iren && m_starve == LIMIT)) begin
        m_owner  = 2;
        m_dwrite = bus.dwen;
        m_starve = bus.iren ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      end else if (bus.iren) begin
        m_owner  = 1;
        m_starve = 0;
      end
    end else if (m_owner == 1) begin
      if (!bus.iren || bus.ram_ready) m_owner = 0;
    end else if (bus.ram_ready) begin
      m_owner = 0;
    end
    #1;

    // Requesters: drop a served request unless told to keep presenting it.
    if (e_ihit && !hold_i) bus.iren = 1'b0;
    if (e_dhit && !hold_d) begin bus.dren = 1'b0; bus.dwen = 1'b0; end
    if (rand_mode) begin
      if (!bus.iren && $urandom_range(0, 2) == 0) begin
        bus.iren  = 1'b1;
        bus.iaddr = $urandom & 32'hFFFF_FFFC;
      end else if (bus.iren && m_owner == 1 && $urandom_range(0, 9) == 0) begin
        bus.iren = 1'b0;
      end
      if (!(bus.dren || bus.dwen) && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    begin bus.dren = 1'b1; bus.dwen = 1'b0; end
          2:       begin bus.dren = 1'b0; bus.dwen = 1'b1; end
          default: begin bus.dren = 1'b1; bus.dwen = 1'b1; end
        endcase
        bus.daddr  = $urandom;
        bus.dstore = $urandom;
      end
    end

    // Memory: ready after mem_lat strobe cycles, or randomly when mem_lat is 0.
    if (m_owner != 0) acc_cyc++; else acc_cyc = 0;
    if (mem_lat == 0)
      bus.ram_ready = ($urandom_range(0, 2) == 0);
    else
      bus.ram_ready = (m_owner != 0) && (acc_cyc == mem_lat);
    bus.ram_load = rand_load ? $urandom : fixed_load;
  endtask

  initial begin
    rst = 1'b1;
    bus.iren = 0; bus.iaddr = 0; bus.dren = 0; bus.dwen = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ram_load = 0; bus.ram_ready = 0;
    clear_obs();
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_ren",  32'(bus.ram_ren), 32'd0);

    // Instruction fetch alone, memory ready on the second strobe cycle.
    clear_obs();
    mem_lat = 2; rand_load = 0; fixed_load = 32'h0000_0013;
    bus.iaddr = 32'h40; bus.iren = 1'b1;
    repeat (5) cycle();
    chk("ionly_ren_cycles", 32'(ren_cnt), 32'd2);
    chk("ionly_ihits", 32'(ihits), 32'd1);
    chk("ionly_iload", last_iload, 32'h0000_0013);
    chk("ionly_dhits", 32'(dhits), 32'd0);

    // Simultaneous requests: data first, then fetch.
    clear_obs();
    mem_lat = 1; rand_load = 1;
    bus.iaddr = 32'h40; bus.iren = 1'b1;
    bus.daddr = 32'h100; bus.dren = 1'b1;
    repeat (8) cycle();
    chk("simul_order", 32'(seq == "DI"), 32'd1);

    // Starvation guard: four data grants, then the fetch is forced through.
    clear_obs();
    hold_d = 1'b1; bus.dren = 1'b1; bus.daddr = 32'h180;
    bus.iren = 1'b1; bus.iaddr = 32'h44;
    repeat (12) cycle();
    chk("starve_first", 32'(seq == "DDDDID"), 32'd1);
    bus.iren = 1'b1; bus.iaddr = 32'h48;
    repeat (10) cycle();
    chk("starve_again", 32'(seq == "DDDDIDDDDDI"), 32'd1);
    hold_d = 1'b0;
    repeat (4) cycle();

    // Fetch flushed after three unready cycles; the coincident ready is ignored.
    clear_obs();
    mem_lat = 4;
    bus.iaddr = 32'h80; bus.iren = 1'b1;
    repeat (4) cycle();
    bus.iren = 1'b0;
    repeat (2) cycle();
    chk("abort_ihits", 32'(ihits), 32'd0);
    chk("abort_ren_cycles", 32'(ren_cnt), 32'd4);
    mem_lat = 1;
    bus.dwen = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'h5555_AAAA;
    repeat (4) cycle();
    chk("abort_then_write", 32'(dhits), 32'd1);

    // Write, ready on the third strobe cycle.
    clear_obs();
    mem_lat = 3;
    bus.dwen = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEAD_BEEF;
    repeat (6) cycle();
    chk("write_wen_cycles", 32'(wen_cnt), 32'd3);
    chk("write_ren_cycles", 32'(ren_cnt), 32'd0);
    chk("write_dhits", 32'(dhits), 32'd1);
    chk("write_dload", last_dload, 32'h0);

    // Reset in the second cycle of a five-cycle read.
    clear_obs();
    mem_lat = 5;
    bus.dren = 1'b1; bus.daddr = 32'h400;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_mid_dhits", 32'(dhits), 32'd0);
    chk("rst_regrant_busy", 32'(bus.busy), 32'd1);
    repeat (6) cycle();
    chk("rst_regrant_dhits", 32'(dhits), 32'd1);

    // Random traffic with flushes, combined read/write requests and resets.
    rand_mode = 1'b1; mem_lat = 0; rand_load = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
